ptmch_spi_snoop: RTL and testbench
==================================

# ptmch_spi_snoop

Passive SPI bus monitor that sits directly upstream of the flash-command pulse counter. It oversamples the SPI flash bus on CLK100M and captures the first byte (opcode) of every chip-select frame. It compares that opcode against five configured command codes and emits a stretched one-hot trigger pulse per match on TRG_PLS. The block never drives the SPI bus.

## Interface
- OPC_PRGEXCT, 8'h10, opcode mapped to TRG_PLS[0] (program execute)
- OPC_RDSTAT, 8'h0F, opcode mapped to TRG_PLS[1] (read status)
- OPC_BLKERS, 8'hD8, opcode mapped to TRG_PLS[2] (128KB block erase)
- OPC_PDREAD, 8'h13, opcode mapped to TRG_PLS[3] (page data read)
- OPC_WRSTAT, 8'h1F, opcode mapped to TRG_PLS[4] (write status)
- PLS_WIDTH, 4, TRG_PLS high time in CLK100M cycles; legal range 2..15
- RESET_N  input  1  asynchronous, active-low reset
- CLK100M  input  1  100 MHz system clock
- SPI_CS_N  input  1  flash chip select from pin; asynchronous
- SPI_SCK  input  1  flash serial clock from pin; asynchronous; SPI mode 0
- SPI_MOSI  input  1  flash data in from pin; asynchronous; MSB first
- TRG_PLS  output  5  per-command trigger pulses, one bit per opcode above
- LAST_OPC  output  8  most recently captured opcode, matched or not
- OPC_STB  output  1  one-cycle strobe when LAST_OPC updates

## Operation
- Sync: SPI_CS_N, SPI_SCK and SPI_MOSI each pass through a 2-FF synchronizer. A third stage on SCK and CS_N provides edge detection.
- SCK rise: sck_s2 & ~sck_s3. CS fall: ~cs_s2 & cs_s3. MOSI is sampled from the synchronizer stage aligned with sck_s2.
- FSM states: IDLE, SHIFT, SKIP.
  - IDLE: on CS fall, clear the bit counter and the shift register, then go to SHIFT.
  - SHIFT: each SCK rise shifts MOSI into bit 0 of shreg (MSB first) and increments a 3-bit counter. When the 8th bit lands, load LAST_OPC, pulse OPC_STB, evaluate the match, and go to SKIP.
  - SKIP: ignore address, data and dummy bytes. On CS high (cs_s2=1), go to IDLE.
  - Any state: if cs_s2=1, go to IDLE. A frame aborted before 8 bits produces no strobe and no pulse.
- Match: compare the captured opcode against all five parameters. Each equal opcode loads its own 4-bit stretch counter with PLS_WIDTH.
  - TRG_PLS[i] = (cnt_i != 0), registered.
  - Each counter decrements to 0 and saturates there.
  - If parameters are set equal, several bits may fire together. This is legal.
- Re-match on a bit whose counter is non-zero reloads that counter. The pulse extends and does not return low.
- An unmatched opcode updates LAST_OPC/OPC_STB only.
- CS fall in SKIP without an intervening CS high is impossible by construction. CS glitches shorter than the synchronizer are not filtered.

## Timing
- Reset values: TRG_PLS=5'b0, LAST_OPC=8'h00, OPC_STB=0, FSM=IDLE, all counters 0, synchronizer stages CS=1 and SCK/MOSI=0.
- Reset asserted mid-frame:
  - All state clears immediately.
  - After release, the block waits in IDLE for the next CS fall, even if CS is already low.
- Bus constraint: SCK high and low times are each ≥ 3 CLK100M cycles (SCK ≤ 16 MHz). MOSI must be stable for ≥ 3 cycles around the SCK rise.
- Latency is measured from the cycle in which sck_s2 first shows the 8th rising edge:
  - OPC_STB and LAST_OPC update 1 cycle later.
  - TRG_PLS rises 2 cycles later.
  - Pin-to-TRG_PLS latency is ≤ 5 CLK100M cycles.
- TRG_PLS[i] stays high exactly PLS_WIDTH cycles per isolated match. The downstream counter's synchronizer and edge detector need ≥ 2 cycles.
- Back-to-back frames: CS high ≥ 3 cycles between frames is required for IDLE re-entry. The minimum frame length (8 SCK × 6 cycles) exceeds the maximum PLS_WIDTH, so successive pulses are always separated by a low gap.

## Structure
- Package ptmch_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, SKIP} snoop_st_t
  - localparam index constants TRG_PRGEXCT=0 … TRG_WRSTAT=4
  - localparam TRG_NUM=5
  - default opcode constants (used as parameter defaults)
- Sub-module ptmch_pls_stretch: one instance per TRG_PLS bit. Parameter PLS_WIDTH; inputs load/clk/reset; output pls. It holds the load/decrement/saturate counter.
- Top: synchronizers, FSM, shift register, compare, 5× ptmch_pls_stretch, generated over TRG_NUM.

## Test plan
- Reset then frame CS low, bytes 0x10,0x00,0x00,0x12 at 10 MHz -> TRG_PLS=5'b00001 for exactly 4 cycles, LAST_OPC=0x10, one OPC_STB, all other bits 0.
- Frames 0x0F, 0xD8, 0x13, 0x1F in sequence -> bits 1,2,3,4 pulse once each in that order; a downstream counter model reads 1 on each.
- Frame 0x9F (JEDEC ID) -> OPC_STB=1, LAST_OPC=0x9F, TRG_PLS stays 0.
- CS rises after 5 bits of 0x10, then a full 0x13 frame follows -> no pulse for the aborted frame; TRG_PLS[3] pulses once; LAST_OPC=0x13.
- A data byte 0x10 sent as the 2nd byte of a 0x03 read frame -> no TRG_PLS; SKIP held until CS high.
- RESET_N asserted during the TRG_PLS[2] pulse and mid-shift of the next frame -> outputs 0 immediately; no pulse until a fresh CS fall with a valid opcode.

Source files
------------

// File: rtl/ptmch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ptmch_pkg
//  Purpose  : Shared types and constants for the SPI opcode snooper.
//  Revision : 1.0  initial release
// ============================================================================
package ptmch_pkg;

   // Snooper frame-tracking states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      SKIP  = 2'd2
   } snoop_st_t;

   // Trigger bit positions on TRG_PLS
   localparam int TRG_PRGEXCT = 0;
   localparam int TRG_RDSTAT  = 1;
   localparam int TRG_BLKERS  = 2;
   localparam int TRG_PDREAD  = 3;
   localparam int TRG_WRSTAT  = 4;
   localparam int TRG_NUM     = 5;

   // Default flash command codes
   localparam logic [7:0] OPC_PRGEXCT_DEF = 8'h10;
   localparam logic [7:0] OPC_RDSTAT_DEF  = 8'h0F;
   localparam logic [7:0] OPC_BLKERS_DEF  = 8'hD8;
   localparam logic [7:0] OPC_PDREAD_DEF  = 8'h13;
   localparam logic [7:0] OPC_WRSTAT_DEF  = 8'h1F;

   // Default trigger high time in CLK100M cycles (legal 2..15)
   localparam int PLS_WIDTH_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/ptmch_pls_stretch.sv
`default_nettype none
// ============================================================================
//  Module   : ptmch_pls_stretch
//  Purpose  : Stretches a one-cycle load into a PLS_WIDTH-cycle pulse; a load
//             while the pulse is active restarts the count so it never drops.
//  Revision : 1.0  initial release
// ============================================================================
module ptmch_pls_stretch
   import ptmch_pkg::*;
#(
   parameter int PLS_WIDTH = PLS_WIDTH_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   output logic o_pls
);

   localparam logic [3:0] c_pls_width = 4'(PLS_WIDTH);

   logic [3:0] r_cnt;
   logic       r_pls;

   // Load, decrement and saturate at zero; pulse mirrors a non-zero count
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= 4'd0;
         r_pls <= 1'b0;
      end else if (i_load) begin
         r_cnt <= c_pls_width;
         r_pls <= 1'b1;
      end else if (r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
         r_pls <= (r_cnt != 4'd1);
      end else begin
         r_pls <= 1'b0;
      end
   end

   assign o_pls = r_pls;

endmodule
`default_nettype wire

// File: rtl/ptmch_spi_snoop.sv
`default_nettype none
// ============================================================================
//  Module   : ptmch_spi_snoop
//  Purpose  : Passive SPI flash monitor. Captures the opcode of each
//             chip-select frame and fires a stretched trigger per match.
//  Revision : 1.0  initial release
// ============================================================================
module ptmch_spi_snoop
   import ptmch_pkg::*;
#(
   parameter logic [7:0] OPC_PRGEXCT = OPC_PRGEXCT_DEF,
   parameter logic [7:0] OPC_RDSTAT  = OPC_RDSTAT_DEF,
   parameter logic [7:0] OPC_BLKERS  = OPC_BLKERS_DEF,
   parameter logic [7:0] OPC_PDREAD  = OPC_PDREAD_DEF,
   parameter logic [7:0] OPC_WRSTAT  = OPC_WRSTAT_DEF,
   parameter int         PLS_WIDTH   = PLS_WIDTH_DEF
) (
   input  logic         RESET_N,
   input  logic         CLK100M,
   input  logic         SPI_CS_N,
   input  logic         SPI_SCK,
   input  logic         SPI_MOSI,
   output logic [4:0]   TRG_PLS,
   output logic [7:0]   LAST_OPC,
   output logic         OPC_STB
);

   logic         r_cs_s1, r_cs_s2, r_cs_s3;
   logic         r_sck_s1, r_sck_s2, r_sck_s3;
   logic         r_mosi_s1, r_mosi_s2;
   logic [1:0]   r_settle;
   logic         r_arm;
   snoop_st_t    r_state;
   logic [2:0]   r_bit_cnt;
   logic [6:0]   r_shreg;
   logic [7:0]   r_last_opc;
   logic         r_opc_stb;

   logic         w_sck_rise;
   logic         w_cs_fall;
   logic [7:0]   w_opc_next;
   logic [7:0]   w_opc_tab [TRG_NUM];
   logic [4:0]   w_load;
   logic [4:0]   w_trg;

   // Two-flop synchronizers plus a third stage on SCK/CS for edge detection
   always_ff @(posedge CLK100M or negedge RESET_N) begin
      if (!RESET_N) begin
         r_cs_s1   <= 1'b1;
         r_cs_s2   <= 1'b1;
         r_cs_s3   <= 1'b1;
         r_sck_s1  <= 1'b0;
         r_sck_s2  <= 1'b0;
         r_sck_s3  <= 1'b0;
         r_mosi_s1 <= 1'b0;
         r_mosi_s2 <= 1'b0;
      end else begin
         r_cs_s1   <= SPI_CS_N;
         r_cs_s2   <= r_cs_s1;
         r_cs_s3   <= r_cs_s2;
         r_sck_s1  <= SPI_SCK;
         r_sck_s2  <= r_sck_s1;
         r_sck_s3  <= r_sck_s2;
         r_mosi_s1 <= SPI_MOSI;
         r_mosi_s2 <= r_mosi_s1;
      end
   end

   // The CS reset value is high, so a low pin at release would look like a
   // fall; only accept falls once CS has really been seen high after reset.
   always_ff @(posedge CLK100M or negedge RESET_N) begin
      if (!RESET_N) begin
         r_settle <= 2'd0;
         r_arm    <= 1'b0;
      end else begin
         if (r_settle != 2'd2) begin
            r_settle <= r_settle + 2'd1;
         end
         if ((r_settle == 2'd2) && r_cs_s2) begin
            r_arm <= 1'b1;
         end
      end
   end

   assign w_sck_rise = r_sck_s2 & ~r_sck_s3;
   assign w_cs_fall  = r_arm & ~r_cs_s2 & r_cs_s3;
   assign w_opc_next = {r_shreg, r_mosi_s2};

   // Frame tracker: capture first byte after CS fall, then ignore the rest
   always_ff @(posedge CLK100M or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state    <= IDLE;
         r_bit_cnt  <= 3'd0;
         r_shreg    <= 7'd0;
         r_last_opc <= 8'h00;
         r_opc_stb  <= 1'b0;
      end else begin
         r_opc_stb <= 1'b0;
         if (r_cs_s2) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_cs_fall) begin
                     r_bit_cnt <= 3'd0;
                     r_shreg   <= 7'd0;
                     r_state   <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (w_sck_rise) begin
                     r_shreg   <= {r_shreg[5:0], r_mosi_s2};
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_last_opc <= w_opc_next;
                        r_opc_stb  <= 1'b1;
                        r_state    <= SKIP;
                     end
                  end
               end
               SKIP: begin
                  r_state <= SKIP;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign w_opc_tab[TRG_PRGEXCT] = OPC_PRGEXCT;
   assign w_opc_tab[TRG_RDSTAT]  = OPC_RDSTAT;
   assign w_opc_tab[TRG_BLKERS]  = OPC_BLKERS;
   assign w_opc_tab[TRG_PDREAD]  = OPC_PDREAD;
   assign w_opc_tab[TRG_WRSTAT]  = OPC_WRSTAT;

   // Each matching command restarts its own stretcher on the capture strobe
   for (genvar gi = 0; gi < TRG_NUM; gi++) begin : g_trg
      assign w_load[gi] = r_opc_stb & (r_last_opc == w_opc_tab[gi]);

      ptmch_pls_stretch #(
         .PLS_WIDTH (PLS_WIDTH)
      ) u_stretch (
         .i_clk   (CLK100M),
         .i_rst_n (RESET_N),
         .i_load  (w_load[gi]),
         .o_pls   (w_trg[gi])
      );
   end

   assign TRG_PLS  = w_trg;
   assign LAST_OPC = r_last_opc;
   assign OPC_STB  = r_opc_stb;

endmodule
`default_nettype wire

// File: tb/tb_ptmch_spi_snoop.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ptmch_spi_snoop
//  Purpose  : Directed self-checking bench for the SPI opcode snooper.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ptmch_spi_snoop;

   logic       clk;
   logic       rst_n;
   logic       cs_n;
   logic       sck;
   logic       mosi;
   logic [4:0] trg;
   logic [7:0] last_opc;
   logic       opc_stb;

   int n_chk;
   int n_fail;

   // Pulse monitor state
   int         rise_cnt [5];
   int         run_len  [5];
   int         width    [5];
   time        t_rise   [5];
   logic [4:0] prev;
   int         stb_cnt;
   time        t_stb;
   int         order_log [64];
   int         order_n;

   // Snapshots taken at the start of each scenario
   int  base_rise [5];
   int  base_stb;
   int  base_ord;
   time t_sck;

   ptmch_spi_snoop dut (
      .RESET_N  (rst_n),
      .CLK100M  (clk),
      .SPI_CS_N (cs_n),
      .SPI_SCK  (sck),
      .SPI_MOSI (mosi),
      .TRG_PLS  (trg),
      .LAST_OPC (last_opc),
      .OPC_STB  (opc_stb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Downstream-counter model: count rising edges and high time per bit
   initial begin
      prev    = 5'b0;
      stb_cnt = 0;
      order_n = 0;
      t_stb   = 0;
      for (int i = 0; i < 5; i++) begin
         rise_cnt[i] = 0; run_len[i] = 0; width[i] = 0; t_rise[i] = 0;
      end
      forever begin
         @(negedge clk);
         if (opc_stb === 1'b1) begin
            stb_cnt++;
            t_stb = $time;
         end
         for (int i = 0; i < 5; i++) begin
            if (trg[i] === 1'b1) begin
               if (!prev[i]) begin
                  rise_cnt[i]++;
                  t_rise[i] = $time;
                  order_log[order_n % 64] = i;
                  order_n++;
                  run_len[i] = 0;
               end
               run_len[i]++;
            end else if (prev[i]) begin
               width[i] = run_len[i];
            end
            prev[i] = (trg[i] === 1'b1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required below 200000", $time);
      $fatal(1);
   end

   function automatic int d_rise(input int i);
      return rise_cnt[i] - base_rise[i];
   endfunction

   function automatic int d_all();
      int s;
      s = 0;
      for (int i = 0; i < 5; i++) s += rise_cnt[i] - base_rise[i];
      return s;
   endfunction

   task automatic snap();
      for (int i = 0; i < 5; i++) base_rise[i] = rise_cnt[i];
      base_stb = stb_cnt;
      base_ord = order_n;
   endtask

   task automatic align();
      @(posedge clk);
      #3;
   endtask

   task automatic frame_start();
      align();
      cs_n = 1'b0;
      #50;
   endtask

   task automatic frame_end();
      #50;
      cs_n = 1'b1;
      #300;
   endtask

   // Mode 0, MSB first, 10 MHz: data set while SCK low, sampled on the rise
   task automatic spi_bits(input logic [7:0] b, input int hi, input int lo);
      for (int k = hi; k >= lo; k--) begin
         mosi = b[k];
         #50;
         sck   = 1'b1;
         t_sck = $time;
         #50;
         sck = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cs_n  = 1'b1;
      sck   = 1'b0;
      mosi  = 1'b0;
      #47;
      n_chk++;
      if (trg !== 5'b0) begin
         n_fail++; $display("FAIL reset_trg: got %b required %b", trg, 5'b0);
      end
      n_chk++;
      if (last_opc !== 8'h00) begin
         n_fail++; $display("FAIL reset_last: got %h required %h", last_opc, 8'h00);
      end
      n_chk++;
      if (opc_stb !== 1'b0) begin
         n_fail++; $display("FAIL reset_stb: got %b required %b", opc_stb, 1'b0);
      end
      rst_n = 1'b1;
      #200;
   endtask

   task automatic test_prgexct();
      time t8;
      snap();
      frame_start();
      spi_bits(8'h10, 7, 0);
      t8 = t_sck;
      spi_bits(8'h00, 7, 0);
      spi_bits(8'h00, 7, 0);
      spi_bits(8'h12, 7, 0);
      frame_end();
      n_chk++;
      if (d_rise(0) !== 1) begin
         n_fail++; $display("FAIL prg_rise: got %0d required %0d", d_rise(0), 1);
      end
      n_chk++;
      if (width[0] !== 4) begin
         n_fail++; $display("FAIL prg_width: got %0d required %0d", width[0], 4);
      end
      n_chk++;
      if (d_all() !== 1) begin
         n_fail++; $display("FAIL prg_others: got %0d total rises required %0d", d_all(), 1);
      end
      n_chk++;
      if (last_opc !== 8'h10) begin
         n_fail++; $display("FAIL prg_last: got %h required %h", last_opc, 8'h10);
      end
      n_chk++;
      if (stb_cnt - base_stb !== 1) begin
         n_fail++; $display("FAIL prg_stb: got %0d required %0d", stb_cnt - base_stb, 1);
      end
      n_chk++;
      if ((t_rise[0] - t8) !== 64'd42) begin
         n_fail++; $display("FAIL prg_latency: got %0t required 42", t_rise[0] - t8);
      end
      n_chk++;
      if ((t_rise[0] - t_stb) !== 64'd10) begin
         n_fail++; $display("FAIL prg_stb_to_pls: got %0t required 10", t_rise[0] - t_stb);
      end
   endtask

   task automatic test_sequence();
      logic [7:0] ops [4];
      ops[0] = 8'h0F; ops[1] = 8'hD8; ops[2] = 8'h13; ops[3] = 8'h1F;
      snap();
      for (int f = 0; f < 4; f++) begin
         frame_start();
         spi_bits(ops[f], 7, 0);
         spi_bits(8'hA5, 7, 0);
         frame_end();
      end
      for (int f = 0; f < 4; f++) begin
         n_chk++;
         if (order_log[(base_ord + f) % 64] !== f + 1) begin
            n_fail++; $display("FAIL seq_order%0d: got bit %0d required bit %0d", f, order_log[(base_ord + f) % 64], f + 1);
         end
         n_chk++;
         if (d_rise(f + 1) !== 1 || width[f + 1] !== 4) begin
            n_fail++; $display("FAIL seq_bit%0d: got %0d pulses width %0d required 1 pulse width 4", f + 1, d_rise(f + 1), width[f + 1]);
         end
      end
      n_chk++;
      if (d_all() !== 4 || stb_cnt - base_stb !== 4) begin
         n_fail++; $display("FAIL seq_totals: got %0d rises %0d strobes required 4 and 4", d_all(), stb_cnt - base_stb);
      end
      n_chk++;
      if (last_opc !== 8'h1F) begin
         n_fail++; $display("FAIL seq_last: got %h required %h", last_opc, 8'h1F);
      end
   endtask

   task automatic test_unmatched();
      snap();
      frame_start();
      spi_bits(8'h9F, 7, 0);
      spi_bits(8'h00, 7, 0);
      frame_end();
      n_chk++;
      if (last_opc !== 8'h9F) begin
         n_fail++; $display("FAIL jedec_last: got %h required %h", last_opc, 8'h9F);
      end
      n_chk++;
      if (stb_cnt - base_stb !== 1) begin
         n_fail++; $display("FAIL jedec_stb: got %0d required %0d", stb_cnt - base_stb, 1);
      end
      n_chk++;
      if (d_all() !== 0) begin
         n_fail++; $display("FAIL jedec_trg: got %0d rises required %0d", d_all(), 0);
      end
   endtask

   task automatic test_abort();
      snap();
      frame_start();
      spi_bits(8'h10, 7, 3);
      frame_end();
      n_chk++;
      if (stb_cnt - base_stb !== 0 || d_all() !== 0) begin
         n_fail++; $display("FAIL abort_frame: got %0d strobes %0d rises required 0 and 0", stb_cnt - base_stb, d_all());
      end
      frame_start();
      spi_bits(8'h13, 7, 0);
      spi_bits(8'h00, 7, 0);
      frame_end();
      n_chk++;
      if (d_rise(3) !== 1 || d_all() !== 1) begin
         n_fail++; $display("FAIL abort_next: got bit3 %0d total %0d rises required 1 and 1", d_rise(3), d_all());
      end
      n_chk++;
      if (last_opc !== 8'h13 || stb_cnt - base_stb !== 1) begin
         n_fail++; $display("FAIL abort_last: got %h with %0d strobes required 13 with 1", last_opc, stb_cnt - base_stb);
      end
   endtask

   task automatic test_skip();
      snap();
      frame_start();
      spi_bits(8'h03, 7, 0);
      spi_bits(8'h10, 7, 0);
      spi_bits(8'h0F, 7, 0);
      frame_end();
      n_chk++;
      if (d_all() !== 0) begin
         n_fail++; $display("FAIL skip_trg: got %0d rises required %0d", d_all(), 0);
      end
      n_chk++;
      if (last_opc !== 8'h03 || stb_cnt - base_stb !== 1) begin
         n_fail++; $display("FAIL skip_last: got %h with %0d strobes required 03 with 1", last_opc, stb_cnt - base_stb);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      // Reset while TRG_PLS[2] is high
      frame_start();
      spi_bits(8'hD8, 7, 0);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (trg[2] === 1'b1) seen = 1'b1;
      end
      n_chk++;
      if (!seen) begin
         n_fail++; $display("FAIL rstmid_wait: got no TRG_PLS[2] within 20 cycles required a pulse");
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (trg !== 5'b0 || last_opc !== 8'h00 || opc_stb !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_pulse: got trg %b last %h stb %b required 00000 00 0", trg, last_opc, opc_stb);
      end
      #20;
      rst_n = 1'b1;
      spi_bits(8'h0F, 7, 0);
      frame_end();
      // Reset mid-shift; the rest of the frame must be ignored
      frame_start();
      spi_bits(8'h10, 7, 5);
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (trg !== 5'b0 || last_opc !== 8'h00) begin
         n_fail++; $display("FAIL rstmid_shift: got trg %b last %h required 00000 00", trg, last_opc);
      end
      #19;
      rst_n = 1'b1;
      snap();
      spi_bits(8'h10, 4, 0);
      spi_bits(8'h13, 7, 0);
      spi_bits(8'h1F, 7, 0);
      frame_end();
      n_chk++;
      if (stb_cnt - base_stb !== 0 || d_all() !== 0 || last_opc !== 8'h00) begin
         n_fail++; $display("FAIL rstmid_ignore: got %0d strobes %0d rises last %h required 0 0 00", stb_cnt - base_stb, d_all(), last_opc);
      end
      snap();
      frame_start();
      spi_bits(8'h1F, 7, 0);
      frame_end();
      n_chk++;
      if (d_rise(4) !== 1 || d_all() !== 1 || last_opc !== 8'h1F) begin
         n_fail++; $display("FAIL rstmid_fresh: got bit4 %0d total %0d last %h required 1 1 1F", d_rise(4), d_all(), last_opc);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      test_reset();
      test_prgexct();
      test_sequence();
      test_unmatched();
      test_abort();
      test_skip();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
